// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory bus: the fetch stage issues requests and receives
// in-order read data.
interface instr_fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues credit-limited fetches, tracks in-flight
// addresses, buffers returned words and feeds the IF/ID register. A branch
// flushes everything and discards responses still in flight.
module instr_fetch_stage #(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                PC,
    input  logic                       branch,
    input  logic                       stall,
    instr_fetch_stage_if.master        imem,
    output logic                       pc_advance,
    output logic                       if_id_valid,
    output logic [31:0]                if_id_pc,
    output logic [31:0]                if_id_instr
);
    localparam int unsigned      IDX_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      PTR_W     = IDX_W + 1;
    localparam logic [31:0]      NOP       = 32'h0000_0013;
    localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] MAX_OUT_P = PTR_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] ONE       = PTR_W'(1);

    // Instruction FIFO ({pc, instr}) and in-flight address queue. The
    // address queue shares the FIFO storage size so both can use the
    // wrap-bit pointer scheme; the request credit keeps it within
    // MAX_OUTSTANDING entries.
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]      fifo_pc_d    [FIFO_DEPTH];
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [31:0]      fifo_instr_d [FIFO_DEPTH];
    logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d;
    logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d;
    logic [31:0]      aq_addr_q    [FIFO_DEPTH];
    logic [31:0]      aq_addr_d    [FIFO_DEPTH];
    logic [PTR_W-1:0] aq_wr_q, aq_wr_d;
    logic [PTR_W-1:0] aq_rd_q, aq_rd_d;
    logic [PTR_W-1:0] outstanding_q, outstanding_d;
    logic [PTR_W-1:0] discard_q, discard_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [31:0]      if_id_pc_q, if_id_pc_d;
    logic [31:0]      if_id_instr_q, if_id_instr_d;

    logic [PTR_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             rsp_take;
    logic             rsp_keep;
    logic             req_valid;
    logic             req_accept;
    logic [31:0]      rsp_pc;

    // Credit check and handshake qualification.
    always_comb begin
        fifo_count = fifo_wr_q - fifo_rd_q;
        fifo_empty = (fifo_wr_q[PTR_W-1] == fifo_rd_q[PTR_W-1]) &&
                     (fifo_wr_q[IDX_W-1:0] == fifo_rd_q[IDX_W-1:0]);
        rsp_take   = imem.imem_rsp_valid && (outstanding_q != '0);
        rsp_keep   = rsp_take && (discard_q == '0);
        req_valid  = rst && !branch && (outstanding_q < MAX_OUT_P) &&
                     ((outstanding_q + fifo_count) < DEPTH_P);
        req_accept = req_valid && imem.imem_req_ready;
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = PC;
    assign pc_advance          = req_accept;
    assign if_id_valid         = if_id_valid_q;
    assign if_id_pc            = if_id_pc_q;
    assign if_id_instr         = if_id_instr_q;

    // Next-state: branch flush first, otherwise queue/FIFO/IF-ID updates.
    always_comb begin
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        aq_addr_d     = aq_addr_q;
        aq_wr_d       = aq_wr_q;
        aq_rd_d       = aq_rd_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        rsp_pc        = aq_addr_q[aq_rd_q[IDX_W-1:0]];

        if (branch) begin
            // Everything still in flight after this cycle must be dropped.
            fifo_rd_d     = fifo_wr_q;
            aq_rd_d       = aq_wr_q;
            if_id_valid_d = 1'b0;
            outstanding_d = outstanding_q - PTR_W'(rsp_take);
            discard_d     = outstanding_q - PTR_W'(rsp_take);
        end else begin
            if (req_accept) begin
                aq_addr_d[aq_wr_q[IDX_W-1:0]] = PC;
                aq_wr_d = aq_wr_q + ONE;
            end
            if (rsp_take) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - ONE;
                end else begin
                    aq_rd_d = aq_rd_q + ONE;
                end
            end
            outstanding_d = outstanding_q + PTR_W'(req_accept) - PTR_W'(rsp_take);

            if (!stall) begin
                if (!fifo_empty) begin
                    if_id_valid_d = 1'b1;
                    if_id_pc_d    = fifo_pc_q[fifo_rd_q[IDX_W-1:0]];
                    if_id_instr_d = fifo_instr_q[fifo_rd_q[IDX_W-1:0]];
                    fifo_rd_d     = fifo_rd_q + ONE;
                end else if (rsp_keep) begin
                    // Bypass: response into an empty FIFO goes straight to IF/ID.
                    if_id_valid_d = 1'b1;
                    if_id_pc_d    = rsp_pc;
                    if_id_instr_d = imem.imem_rsp_data;
                end else begin
                    if_id_valid_d = 1'b0;
                end
            end

            if (rsp_keep && !(!stall && fifo_empty)) begin
                fifo_pc_d[fifo_wr_q[IDX_W-1:0]]    = rsp_pc;
                fifo_instr_d[fifo_wr_q[IDX_W-1:0]] = imem.imem_rsp_data;
                fifo_wr_d = fifo_wr_q + ONE;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= NOP;
                aq_addr_q[i]    <= '0;
            end
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            aq_wr_q       <= '0;
            aq_rd_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP;
        end else begin
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
            aq_addr_q     <= aq_addr_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            aq_wr_q       <= aq_wr_d;
            aq_rd_q       <= aq_rd_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: in-order memory responder plus a queue-based
// model of which fetched words reach IF/ID and when new fetches are allowed.
module tb_instr_fetch_stage;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned MAX_OUT = 2;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        branch;
    logic        stall;
    logic        pc_advance;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    instr_fetch_stage_if bus ();

    instr_fetch_stage #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .branch      (branch),
        .stall       (stall),
        .imem        (bus.master),
        .pc_advance  (pc_advance),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Stimulus controls
    logic [31:0] pc_in;
    logic        br_in, st_in, rdy_in, rsp_allow, rsp_force;

    // Model state: memory's pending requests, kept words awaiting IF/ID
    logic [31:0] mem_q[$];
    logic [31:0] buf_q[$];
    int unsigned skip;
    logic        m_valid;
    logic [31:0] m_pc;

    // Per-cycle samples of combinational outputs
    logic        exp_rv, exp_adv, act_rv, act_adv;
    logic [31:0] act_addr, pc_used;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_clear();
        mem_q.delete();
        buf_q.delete();
        skip    = 0;
        m_valid = 1'b0;
        m_pc    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        pc_in = '0; br_in = 1'b0; st_in = 1'b0;
        rdy_in = 1'b1; rsp_allow = 1'b1; rsp_force = 1'b0;
    endtask

    // One clock: drive inputs, sample comb outputs, advance model, clock edge.
    task automatic tick();
        logic        rsp, took, acc;
        logic [31:0] a;
        rsp = rsp_force || (rsp_allow && mem_q.size() > 0);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = (mem_q.size() > 0) ? memf(mem_q[0]) : 32'hBAD0_0BAD;
        bus.imem_req_ready = rdy_in;
        PC = pc_in; branch = br_in; stall = st_in;
        #2;
        exp_rv   = !br_in && (mem_q.size() < MAX_OUT) && (mem_q.size() + buf_q.size() < DEPTH);
        exp_adv  = exp_rv && rdy_in;
        act_rv   = bus.imem_req_valid;
        act_adv  = pc_advance;
        act_addr = bus.imem_addr;
        pc_used  = pc_in;
        acc  = exp_adv;
        took = rsp && mem_q.size() > 0;
        a    = took ? mem_q.pop_front() : 32'h0;
        if (br_in) begin
            skip = mem_q.size();
            buf_q.delete();
            m_valid = 1'b0;
        end else begin
            if (took) begin
                if (skip > 0) skip--;
                else buf_q.push_back(a);
            end
            if (acc) mem_q.push_back(pc_in);
            if (!st_in) begin
                if (buf_q.size() > 0) begin
                    m_valid = 1'b1;
                    m_pc = buf_q.pop_front();
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        if (acc) pc_in = pc_in + 32'd4;
        rsp_force = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if_id_valid); end
        total++; if (if_id_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", if_id_pc); end
        total++; if (if_id_instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h want=00000013", if_id_instr); end
        total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.imem_req_valid); end
        do_reset();
        repeat (3) tick();
        rst = 1'b0;
        #1;
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", if_id_valid); end
        total++; if (if_id_pc !== 32'h0) begin bad++; $display("FAIL midrst_pc got=%h want=0", if_id_pc); end
        total++; if (if_id_instr !== 32'h13) begin bad++; $display("FAIL midrst_instr got=%h want=00000013", if_id_instr); end
        total++; if (bus.imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b/%b want=0/0", bus.imem_req_valid, pc_advance); end
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        pc_in = 32'h200;
        tick();
        total++; if (act_rv !== 1'b1 || act_adv !== 1'b1) begin bad++; $display("FAIL postrst_req got=%b/%b want=1/1", act_rv, act_adv); end
        total++; if (act_addr !== 32'h200) begin bad++; $display("FAIL postrst_addr got=%h want=00000200", act_addr); end
    endtask

    task automatic test_streaming();
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc%0d got=%b/%h want=1/%h", i, if_id_valid, if_id_pc, 32'(4 * i)); end
            total++; if (if_id_instr !== memf(32'(4 * i))) begin bad++; $display("FAIL stream_instr%0d got=%h want=%h", i, if_id_instr, memf(32'(4 * i))); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) tick();
        st_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'd4) begin bad++; $display("FAIL stall_hold%0d got=%b/%h want=1/00000004", i, if_id_valid, if_id_pc); end
            if (i > 0) begin
                total++; if (act_rv !== 1'b0) begin bad++; $display("FAIL stall_req%0d got=%b want=0", i, act_rv); end
            end
        end
        st_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(8 + 4 * i)) begin bad++; $display("FAIL stall_drain%0d got=%b/%h want=1/%h", i, if_id_valid, if_id_pc, 32'(8 + 4 * i)); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        tick();
        tick();
        rsp_allow = 1'b0; st_in = 1'b1;
        tick();
        br_in = 1'b1; st_in = 1'b0;
        tick();
        total++; if (act_rv !== 1'b0) begin bad++; $display("FAIL flush_blockreq got=%b want=0", act_rv); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%b want=0", if_id_valid); end
        br_in = 1'b0; pc_in = 32'h40; rsp_allow = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL flush_drop%0d got=%b want=0", i, if_id_valid); end
        end
        tick();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h40) begin bad++; $display("FAIL flush_target got=%b/%h want=1/00000040", if_id_valid, if_id_pc); end
        total++; if (if_id_instr !== memf(32'h40)) begin bad++; $display("FAIL flush_instr got=%h want=%h", if_id_instr, memf(32'h40)); end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (3) tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (act_addr !== 32'd12 || act_rv !== 1'b1) begin bad++; $display("FAIL bp_addr%0d got=%h/%b want=0000000c/1", i, act_addr, act_rv); end
            total++; if (act_adv !== 1'b0) begin bad++; $display("FAIL bp_adv%0d got=%b want=0", i, act_adv); end
            if (i == 0) begin
                total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'd8) begin bad++; $display("FAIL bp_last got=%b/%h want=1/00000008", if_id_valid, if_id_pc); end
            end else begin
                total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL bp_drain%0d got=%b want=0", i, if_id_valid); end
            end
        end
        rdy_in = 1'b1;
    endtask

    task automatic test_branch_stall_rsp();
        do_reset();
        tick();
        tick();
        rsp_allow = 1'b0; st_in = 1'b1;
        tick();
        br_in = 1'b1; st_in = 1'b1; rsp_allow = 1'b1;
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL bsr_clear got=%b want=0", if_id_valid); end
        br_in = 1'b0; st_in = 1'b0; pc_in = 32'h80;
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL bsr_drop got=%b/%h want=0", if_id_valid, if_id_pc); end
        total++; if (act_adv !== 1'b1) begin bad++; $display("FAIL bsr_req got=%b want=1", act_adv); end
        tick();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h80) begin bad++; $display("FAIL bsr_target got=%b/%h want=1/00000080", if_id_valid, if_id_pc); end
    endtask

    task automatic test_protocol_error();
        do_reset();
        rdy_in = 1'b0; rsp_allow = 1'b0; rsp_force = 1'b1;
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL perr_valid got=%b want=0", if_id_valid); end
        rdy_in = 1'b1;
        tick();
        total++; if (act_rv !== 1'b1 || act_adv !== 1'b1) begin bad++; $display("FAIL perr_req got=%b/%b want=1/1", act_rv, act_adv); end
        rsp_allow = 1'b1; rdy_in = 1'b0;
        tick();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin bad++; $display("FAIL perr_fetch got=%b/%h want=1/00000000", if_id_valid, if_id_pc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rdy_in    = ($urandom_range(0, 3) != 0);
            rsp_allow = ($urandom_range(0, 9) < 7);
            st_in     = ($urandom_range(0, 3) == 0);
            br_in     = ($urandom_range(0, 15) == 0);
            tick();
            if (br_in) pc_in = 32'($urandom_range(0, 1023)) << 2;
            total++; if (act_rv !== exp_rv || act_adv !== exp_adv) begin bad++; $display("FAIL rnd_req@%0d got=%b/%b want=%b/%b", i, act_rv, act_adv, exp_rv, exp_adv); end
            total++; if (act_addr !== pc_used) begin bad++; $display("FAIL rnd_addr@%0d got=%h want=%h", i, act_addr, pc_used); end
            total++; if (if_id_valid !== m_valid) begin bad++; $display("FAIL rnd_valid@%0d got=%b want=%b", i, if_id_valid, m_valid); end
            if (m_valid) begin
                total++; if (if_id_pc !== m_pc || if_id_instr !== memf(m_pc)) begin bad++; $display("FAIL rnd_word@%0d got=%h/%h want=%h/%h", i, if_id_pc, if_id_instr, m_pc, memf(m_pc)); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        PC = '0; branch = 1'b0; stall = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        pc_in = '0; br_in = 1'b0; st_in = 1'b0;
        rdy_in = 1'b1; rsp_allow = 1'b1; rsp_force = 1'b0;
        model_clear();
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_backpressure();
        test_branch_stall_rsp();
        test_protocol_error();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning fetched-instruction buffer entries (power of 2, 2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum accepted-but-unanswered memory requests (1..FIFO_DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port PC  input  32  fetch address from the PC updater.
REQ-006 SHALL have port branch  input  1  redirect pulse; flushes all in-flight fetches.
REQ-007 SHALL have port stall  input  1  decode stage cannot accept an instruction this cycle.
REQ-008 SHALL have port imem_req_valid  output  1  request presented to instruction memory.
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 SHALL have port imem_addr  output  32  request address.
REQ-011 SHALL have port imem_rsp_valid  input  1  read data valid; responses return in request order.
REQ-012 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-013 SHALL have port pc_advance  output  1  request accepted; PC updater may step to PC+4.
REQ-014 SHALL have port if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-015 SHALL have port if_id_pc  output  32  address of the held instruction.
REQ-016 SHALL have port if_id_instr  output  32  held instruction word.

Function
REQ-017 SHALL assert imem_req_valid when not branch, outstanding < MAX_OUTSTANDING and outstanding + buffered < FIFO_DEPTH; imem_addr = PC.
REQ-018 SHALL treat a request as accepted when imem_req_valid && imem_req_ready; pc_advance = that AND combinationally, same cycle.
REQ-019 SHALL push the accepted address into an address queue (depth MAX_OUTSTANDING) and increment outstanding.
REQ-020 SHALL, on imem_rsp_valid with discard count 0, pop the address queue and write {addr, data} into the instruction FIFO; outstanding decrements.
REQ-021 SHALL, on imem_rsp_valid with discard count > 0, drop the data and decrement discard count and outstanding.
REQ-022 SHALL, when stall = 0, load IF/ID from the FIFO head (if_id_valid = 1) or clear if_id_valid if the FIFO is empty; stall = 1 holds IF/ID unchanged.
REQ-023 SHALL bypass: response written into an empty FIFO appears in IF/ID at the next edge (1-cycle response-to-IF/ID latency).
REQ-024 SHALL, on branch = 1: clear FIFO, address queue, if_id_valid; set discard count = outstanding minus any response consumed that cycle; block requests that cycle.
REQ-025 SHALL give branch priority over stall, responses and new requests in the same cycle.
REQ-026 SHALL handle simultaneous request accept and response in one cycle (outstanding unchanged).
REQ-027 SHALL never overflow the FIFO: REQ-017 credit guarantees space for every outstanding response.
REQ-028 SHALL use wrap-around pointers of log2(depth)+1 bits; full/empty from MSB compare.
REQ-029 SHALL ignore imem_rsp_valid when outstanding = 0 (protocol error, no state change).

Reset
REQ-030 SHALL, while rst = 0, immediately force if_id_valid = 0, if_id_pc = 0, if_id_instr = 32'h00000013 (NOP), outstanding = 0, discard = 0, FIFO/queue empty, imem_req_valid = 0.
REQ-031 SHALL resume requesting at the first rising clk after rst deasserts; reset mid-transaction abandons responses (memory reset together).

Verification
REQ-032 Reset: rst = 0 mid-fetch -> outputs at REQ-030 values before next edge; first request after release with imem_addr = PC.
REQ-033 Streaming: ready = 1, rsp 1 cycle later, PC 0,4,8 -> if_id_pc 0,4,8 on consecutive cycles, no bubbles.
REQ-034 Stall: stall = 1 for 3 cycles -> IF/ID held, FIFO fills to 2, imem_req_valid drops, no lost/duplicated words.
REQ-035 Flush: branch with 2 outstanding -> both later responses dropped; next if_id_pc equals redirected PC (e.g. 0x40).
REQ-036 Backpressure: imem_req_ready = 0 for 4 cycles -> imem_addr stable, pc_advance = 0, if_id_valid falls after drain.
REQ-037 Same-cycle branch + stall + rsp_valid -> flush wins, if_id_valid = 0, discard = outstanding - 1.
